// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Brief    : EX-stage branch/jump resolution with mispredict detection, a
//            valid/ready result pipeline (1 or 2 stages), flush and saturating
//            branch/mispredict statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    // Payload layout: {illegal, mispredict, taken, resolved_target}
    localparam int              c_pay_w     = XLEN + 3;
    localparam int              c_taken_b   = XLEN;
    localparam int              c_mis_b     = XLEN + 1;
    localparam int              c_ill_b     = XLEN + 2;
    localparam logic [XLEN-1:0] c_four      = XLEN'(4);
    localparam logic [XLEN-1:0] c_lsb_clear = ~(XLEN'(1));
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Combinational resolution
    // ------------------------------------------------------------------------
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_target;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_resolved;
    logic            w_cond;
    logic            w_f3_illegal;
    logic            w_taken;
    logic            w_illegal;
    logic            w_mispredict;
    logic [c_pay_w-1:0] w_pay;

    assign w_eq        = (in_rs1 == in_rs2);
    assign w_lt_s      = ($signed(in_rs1) < $signed(in_rs2));
    assign w_lt_u      = (in_rs1 < in_rs2);
    assign w_pc_plus4  = in_pc + c_four;
    assign w_pc_target = in_pc + in_imm;
    assign w_jalr_sum  = in_rs1 + in_imm;

    always_comb begin
        w_cond       = 1'b0;
        w_f3_illegal = 1'b0;
        case (in_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt_s;
            3'b101:  w_cond = !w_lt_s;
            3'b110:  w_cond = w_lt_u;
            3'b111:  w_cond = !w_lt_u;
            default: w_f3_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_target  = w_pc_target;
        case (in_kind)
            2'b00: begin
                w_taken   = w_cond;
                w_illegal = w_f3_illegal;
            end
            2'b01: w_taken = 1'b1;
            2'b10: begin
                w_taken  = 1'b1;
                w_target = w_jalr_sum & c_lsb_clear;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_resolved   = w_taken ? w_target : w_pc_plus4;
    // Target only matters when both actual and predicted directions are taken
    assign w_mispredict = (w_taken != in_pred_taken) |
                          (w_taken & in_pred_taken & (w_target != in_pred_target));
    assign w_pay        = {w_illegal, w_mispredict, w_taken, w_resolved};

    // ------------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------------
    logic               r_s1_valid;
    logic [c_pay_w-1:0] r_s1_pay;
    logic               w_s1_drain;
    logic               w_accept;
    logic               w_out_valid;
    logic [c_pay_w-1:0] w_out_pay;
    logic               w_handshake;

    assign in_ready = !r_s1_valid | w_s1_drain;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pay   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_pay   <= w_pay;
        end else if (w_s1_drain) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Optional stage 2 (plain copy of stage 1)
    // ------------------------------------------------------------------------
    generate
        if (STAGES == 2) begin : g_two_stage
            logic               r_s2_valid;
            logic [c_pay_w-1:0] r_s2_pay;
            logic               w_s2_free;

            assign w_s2_free  = !r_s2_valid | out_ready;
            assign w_s1_drain = r_s1_valid & w_s2_free;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_valid <= 1'b0;
                    r_s2_pay   <= '0;
                end else if (flush) begin
                    r_s2_valid <= 1'b0;
                end else if (w_s1_drain) begin
                    r_s2_valid <= 1'b1;
                    r_s2_pay   <= r_s1_pay;
                end else if (out_ready) begin
                    r_s2_valid <= 1'b0;
                end
            end

            assign w_out_valid = r_s2_valid;
            assign w_out_pay   = r_s2_pay;
        end else begin : g_one_stage
            assign w_s1_drain  = r_s1_valid & out_ready;
            assign w_out_valid = r_s1_valid;
            assign w_out_pay   = r_s1_pay;
        end
    endgenerate

    assign out_valid      = w_out_valid;
    assign out_target     = w_out_pay[XLEN-1:0];
    assign out_taken      = w_out_pay[c_taken_b];
    assign out_mispredict = w_out_pay[c_mis_b];
    assign out_illegal    = w_out_pay[c_ill_b];

    // ------------------------------------------------------------------------
    // Statistics; a handshake in a flush cycle still counts
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    assign w_handshake = w_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_mis_cnt    <= '0;
        end else if (w_handshake) begin
            if (r_branch_cnt != c_cnt_max) begin
                r_branch_cnt <= r_branch_cnt + c_cnt_one;
            end
            if (w_out_pay[c_mis_b] && (r_mis_cnt != c_cnt_max)) begin
                r_mis_cnt <= r_mis_cnt + c_cnt_one;
            end
        end
    end

    assign branch_count     = r_branch_cnt;
    assign mispredict_count = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve
// Brief    : Table-driven, scoreboarded bench for branch_resolve (STAGES=1,
//            STAGES=2, and CNT_W=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ptg;
        logic        taken;
        logic [31:0] tgt;
        logic        mis;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
        logic        mis;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  kind;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, imm, ptg;
    logic        pt;

    logic        d1_in_valid, d1_in_ready, d1_flush, d1_out_valid, d1_out_ready;
    logic        d1_out_taken, d1_out_mis, d1_out_ill;
    logic [31:0] d1_out_target, d1_bc, d1_mc;

    logic        d2_in_valid, d2_in_ready, d2_flush, d2_out_valid, d2_out_ready;
    logic        d2_out_taken, d2_out_mis, d2_out_ill;
    logic [31:0] d2_out_target, d2_bc, d2_mc;

    logic        d3_in_valid, d3_in_ready, d3_flush, d3_out_valid, d3_out_ready;
    logic        d3_out_taken, d3_out_mis, d3_out_ill;
    logic [31:0] d3_out_target;
    logic [1:0]  d3_bc, d3_mc;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[14];
    exp_t cur_exp;
    exp_t q1[$];
    exp_t q2[$];
    logic d1_rand;

    branch_resolve #(.XLEN(32), .STAGES(1), .CNT_W(32)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_kind(kind), .in_funct3(funct3), .in_rs1(rs1), .in_rs2(rs2),
        .in_pc(pc), .in_imm(imm), .in_pred_taken(pt), .in_pred_target(ptg),
        .flush(d1_flush), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_taken(d1_out_taken), .out_target(d1_out_target),
        .out_mispredict(d1_out_mis), .out_illegal(d1_out_ill),
        .branch_count(d1_bc), .mispredict_count(d1_mc)
    );

    branch_resolve #(.XLEN(32), .STAGES(2), .CNT_W(32)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_kind(kind), .in_funct3(funct3), .in_rs1(rs1), .in_rs2(rs2),
        .in_pc(pc), .in_imm(imm), .in_pred_taken(pt), .in_pred_target(ptg),
        .flush(d2_flush), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_taken(d2_out_taken), .out_target(d2_out_target),
        .out_mispredict(d2_out_mis), .out_illegal(d2_out_ill),
        .branch_count(d2_bc), .mispredict_count(d2_mc)
    );

    branch_resolve #(.XLEN(32), .STAGES(1), .CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .in_kind(kind), .in_funct3(funct3), .in_rs1(rs1), .in_rs2(rs2),
        .in_pc(pc), .in_imm(imm), .in_pred_taken(pt), .in_pred_target(ptg),
        .flush(d3_flush), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .out_taken(d3_out_taken), .out_target(d3_out_target),
        .out_mispredict(d3_out_mis), .out_illegal(d3_out_ill),
        .branch_count(d3_bc), .mispredict_count(d3_mc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input int i);
        kind    = tbl[i].kind;
        funct3  = tbl[i].f3;
        rs1     = tbl[i].rs1;
        rs2     = tbl[i].rs2;
        pc      = tbl[i].pc;
        imm     = tbl[i].imm;
        pt      = tbl[i].pt;
        ptg     = tbl[i].ptg;
        cur_exp = '{tbl[i].taken, tbl[i].tgt, tbl[i].mis, tbl[i].ill};
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_d1(input int i);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        drive(i);
        d1_in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = d1_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL d1_accept_timeout vector=%0d actual=not_accepted required=accepted", i);
        end
        d1_in_valid = 1'b0;
    endtask

    // Scoreboard: pop on output handshake, push on acceptance
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            if (d1_out_valid && d1_out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d1_unexpected_output actual=valid required=none");
                end else begin
                    e = q1.pop_front();
                    chk("d1_taken", d1_out_taken, e.taken);
                    chk("d1_target", d1_out_target, e.tgt);
                    chk("d1_mispredict", d1_out_mis, e.mis);
                    chk("d1_illegal", d1_out_ill, e.ill);
                end
            end
            if (d1_flush) q1.delete();
            else if (d1_in_valid && d1_in_ready) q1.push_back(cur_exp);

            if (d2_out_valid && d2_out_ready) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d2_unexpected_output actual=valid required=none");
                end else begin
                    e = q2.pop_front();
                    chk("d2_taken", d2_out_taken, e.taken);
                    chk("d2_target", d2_out_target, e.tgt);
                    chk("d2_mispredict", d2_out_mis, e.mis);
                    chk("d2_illegal", d2_out_ill, e.ill);
                end
            end
            if (d2_flush) q2.delete();
            else if (d2_in_valid && d2_in_ready) q2.push_back(cur_exp);
        end
    end

    // Output must hold while stalled
    logic        hold_prev = 1'b0;
    logic [34:0] hold_pay;
    always @(negedge clk) begin
        if (rst || d1_flush) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("d1_hold_valid", d1_out_valid, 1);
                chk("d1_hold_payload", {d1_out_ill, d1_out_mis, d1_out_taken, d1_out_target}, hold_pay);
            end
            hold_prev = d1_out_valid && !d1_out_ready;
            hold_pay  = {d1_out_ill, d1_out_mis, d1_out_taken, d1_out_target};
        end
    end

    always @(posedge clk) begin
        if (d1_rand) begin
            #1;
            d1_out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //          kind   f3      rs1           rs2           pc            imm           pt    ptg            taken tgt           mis   ill
        tbl[0]  = '{2'b00, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 1'b0, 32'h00000000, 1'b1, 32'h00000120, 1'b1, 1'b0};
        tbl[1]  = '{2'b00, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 1'b0, 32'h00000000, 1'b0, 32'h00000104, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 3'b000, 32'h00002003, 32'h00000000, 32'h00000300, 32'h00000000, 1'b1, 32'h00002002, 1'b1, 32'h00002002, 1'b0, 1'b0};
        tbl[3]  = '{2'b00, 3'b000, 32'h00000005, 32'h00000005, 32'hFFFFFFFC, 32'h00000008, 1'b1, 32'h00000004, 1'b1, 32'h00000004, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 3'b010, 32'h00000005, 32'h00000005, 32'hFFFFFFFC, 32'h00000008, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1};
        tbl[5]  = '{2'b00, 3'b001, 32'h00000005, 32'h00000005, 32'h00000200, 32'h00000040, 1'b1, 32'h00000240, 1'b0, 32'h00000204, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFF0, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFF0, 1'b0, 32'h00000999, 1'b0, 32'h00000014, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 3'b000, 32'h00000000, 32'h00000000, 32'h00001000, 32'h00000800, 1'b1, 32'h00001804, 1'b1, 32'h00001800, 1'b1, 1'b0};
        tbl[9]  = '{2'b11, 3'b000, 32'h00000000, 32'h00000000, 32'h00000050, 32'h00000000, 1'b1, 32'h00000054, 1'b0, 32'h00000054, 1'b1, 1'b1};
        tbl[10] = '{2'b00, 3'b000, 32'h00000003, 32'h00000004, 32'h00000080, 32'h00000010, 1'b1, 32'h00000090, 1'b0, 32'h00000084, 1'b1, 1'b0};
        tbl[11] = '{2'b00, 3'b011, 32'h00000000, 32'h00000000, 32'h00000060, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000064, 1'b0, 1'b1};
        tbl[12] = '{2'b10, 3'b000, 32'h00001000, 32'h00000000, 32'h00000700, 32'h00000003, 1'b1, 32'h00001002, 1'b1, 32'h00001002, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 3'b100, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000400, 32'h0000000C, 1'b1, 32'h0000040C, 1'b1, 32'h0000040C, 1'b0, 1'b0};

        rst = 1'b1;
        d1_in_valid = 1'b0; d1_flush = 1'b0; d1_out_ready = 1'b1; d1_rand = 1'b0;
        d2_in_valid = 1'b0; d2_flush = 1'b0; d2_out_ready = 1'b1;
        d3_in_valid = 1'b0; d3_flush = 1'b0; d3_out_ready = 1'b1;
        drive(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_d1_out_valid", d1_out_valid, 0);
        chk("rst_d1_target", d1_out_target, 0);
        chk("rst_d1_flags", {d1_out_taken, d1_out_mis, d1_out_ill}, 0);
        chk("rst_d1_counts", {d1_bc, d1_mc}, 0);
        chk("rst_d1_in_ready", d1_in_ready, 1);
        chk("rst_d2_in_ready", d2_in_ready, 1);
        chk("rst_d2_out_valid", d2_out_valid, 0);

        // STAGES=1: first vector alone, then the table under random backpressure
        @(posedge clk);
        #1;
        send_d1(0);
        @(negedge clk);
        chk("d1_latency_valid", d1_out_valid, 1);
        chk("d1_mc_before", d1_mc, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("d1_mc_after_blt", d1_mc, 1);
        chk("d1_bc_after_blt", d1_bc, 1);
        @(posedge clk);
        #1;
        d1_rand = 1'b1;
        for (int i = 1; i < 14; i++) send_d1(i);
        d1_rand = 1'b0;
        @(posedge clk);
        #2;
        d1_out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("d1_q_empty", q1.size(), 0);
        chk("d1_branch_count", d1_bc, 14);
        chk("d1_mispredict_count", d1_mc, 5);

        // STAGES=2 backpressure stream
        @(posedge clk);
        #1;
        d2_out_ready = 1'b0;
        drive(0);
        d2_in_valid = 1'b1;
        @(negedge clk);
        chk("d2_ready_first", d2_in_ready, 1);
        @(posedge clk);
        #1;
        drive(1);
        @(negedge clk);
        chk("d2_ready_second", d2_in_ready, 1);
        chk("d2_latency_not_yet", d2_out_valid, 0);
        @(posedge clk);
        #1;
        drive(2);
        @(negedge clk);
        chk("d2_ready_full", d2_in_ready, 0);
        chk("d2_out_valid_full", d2_out_valid, 1);
        chk("d2_head_target", d2_out_target, 32'h120);
        @(posedge clk);
        #1;
        d2_out_ready = 1'b1;
        @(negedge clk);
        chk("d2_ready_resume", d2_in_ready, 1);
        @(posedge clk);
        #1;
        drive(3);
        @(negedge clk);
        chk("d2_ready_fourth", d2_in_ready, 1);
        @(posedge clk);
        #1;
        d2_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("d2_q_empty", q2.size(), 0);
        chk("d2_branch_count", d2_bc, 4);
        chk("d2_mispredict_count", d2_mc, 1);

        // Flush with two in flight and a request presented
        @(posedge clk);
        #1;
        d2_out_ready = 1'b0;
        drive(4);
        d2_in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(5);
        @(posedge clk);
        #1;
        drive(6);
        d2_flush = 1'b1;
        @(negedge clk);
        chk("d2_inflight_valid", d2_out_valid, 1);
        @(posedge clk);
        #1;
        d2_flush = 1'b0;
        d2_in_valid = 1'b0;
        @(negedge clk);
        chk("d2_flush_out_valid", d2_out_valid, 0);
        chk("d2_flush_bc", d2_bc, 4);
        chk("d2_flush_mc", d2_mc, 1);
        chk("d2_flush_in_ready", d2_in_ready, 1);

        // Handshake in the flush cycle still counts
        @(posedge clk);
        #1;
        drive(9);
        d2_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_in_valid = 1'b0;
        @(posedge clk);
        #1;
        d2_flush = 1'b1;
        d2_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d2_flush = 1'b0;
        @(negedge clk);
        chk("d2_hs_flush_bc", d2_bc, 5);
        chk("d2_hs_flush_mc", d2_mc, 2);
        chk("d2_hs_flush_valid", d2_out_valid, 0);
        @(posedge clk);
        #1;
        drive(1);
        d2_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("d2_post_flush_bc", d2_bc, 6);
        chk("d2_post_flush_q", q2.size(), 0);

        // CNT_W=2 saturation over 5 mispredicting handshakes
        @(posedge clk);
        #1;
        d3_in_valid = 1'b1;
        drive(0);  @(posedge clk); #1;
        drive(5);  @(posedge clk); #1;
        drive(8);  @(posedge clk); #1;
        drive(9);  @(posedge clk); #1;
        drive(10); @(posedge clk); #1;
        d3_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("d3_bc_saturate", d3_bc, 3);
        chk("d3_mc_saturate", d3_mc, 3);

        // Reset mid-operation discards in-flight results
        @(posedge clk);
        #1;
        d2_out_ready = 1'b0;
        drive(2);
        d2_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("d2_pre_reset_valid", d2_out_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("d2_mid_reset_valid", d2_out_valid, 0);
        chk("d2_mid_reset_counts", {d2_bc, d2_mc}, 0);
        chk("d2_mid_reset_target", d2_out_target, 0);
        chk("d2_mid_reset_in_ready", d2_in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve.md
# branch_resolve

Parametrised, pipelined branch/jump resolution unit for the EX stage. Evaluates all six RV32I conditional-branch conditions plus JAL/JALR and computes the branch target and fall-through PC. It compares the result against the fetch-stage prediction and raises a redirect on mispredict. Results pass through a valid/ready pipeline of configurable depth, with flush support and saturating branch/mispredict statistics counters.

## Interface
- XLEN, 32, operand and PC width; legal values 32 or 64.
- STAGES, 1, register stages between input and output; legal values 1 or 2.
- CNT_W, 32, width of the statistics counters.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_kind  in  2  request kind: 00 = conditional branch, 01 = JAL, 10 = JALR, 11 = reserved (treated as not-taken and flagged illegal).
- in_funct3  in  3  branch condition (instruction[14:12]); used only when in_kind = 00.
- in_rs1, in_rs2  in  XLEN  source operands.
- in_pc  in  XLEN  PC of the instruction.
- in_imm  in  XLEN  sign-extended immediate.
- in_pred_taken  in  1  fetch-stage prediction.
- in_pred_target  in  XLEN  predicted target.
- flush  in  1  kill all in-flight requests.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  resolved next PC (target if taken, else pc+4).
- out_mispredict  out  1  redirect required; out_target is the redirect PC.
- out_illegal  out  1  funct3 ∈ {010, 011} or in_kind = 11.
- branch_count  out  CNT_W  resolved results delivered.
- mispredict_count  out  CNT_W  delivered results with out_mispredict = 1.

## Operation
- Conditions for in_kind = 00:
  - 000 BEQ: taken if rs1 == rs2.
  - 001 BNE: taken if rs1 != rs2.
  - 100 BLT / 101 BGE: signed compare.
  - 110 BLTU / 111 BGEU: unsigned compare.
  - 010, 011: taken = 0, illegal = 1.
- JAL and JALR are always taken.
- Target computation, all additions modulo 2^XLEN (wrap silently):
  - Branch and JAL: target = pc + imm.
  - JALR: target = (rs1 + imm) with bit 0 forced to 0.
  - Fall-through = pc + 4.
- out_target = taken ? target : pc + 4.
- out_mispredict = (taken != pred_taken) | (taken & pred_taken & (target != pred_target)).
  - A not-taken branch predicted not-taken is never a mispredict, regardless of pred_target.
- All evaluation is combinational on the input and registered into stage 1. Stage 2, when present, is a plain copy.
- Each stage holds a valid bit and payload. Stage k advances when its downstream slot is empty or being drained in the same cycle.
  - in_ready = !s1_valid | s1_advance.
  - Throughput is 1 result per cycle when out_ready is held high.
- Flush:
  - All stage valid bits clear on the next edge.
  - A request presented in the flush cycle is dropped.
  - No counter updates for the dropped request or for any result killed by flush.
  - A result handshaked (out_valid & out_ready) in the flush cycle still counts; the consumer has taken it.
- Counters:
  - branch_count increments on every output handshake.
  - mispredict_count increments on output handshakes with out_mispredict = 1.
  - Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- Reset: all stage valids, out_valid, out_taken, out_mispredict, out_illegal, out_target, branch_count and mispredict_count = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Latency: a request accepted at edge N appears at out_valid after edge N+STAGES−1. STAGES = 1 means the result is visible the cycle after acceptance.
- While out_valid & !out_ready, all output payload fields are held stable.
- Backpressure: with STAGES = 2 and out_ready low, at most 2 results are buffered before in_ready drops.
- rst has priority over flush, and flush has priority over acceptance.
- Reset asserted mid-operation discards all in-flight results.

## Test plan
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 -> taken=1, target=0x120, mispredict=1; mispredict_count 0→1.
- BLTU with the same operands, pred_taken=0 -> taken=0, target=0x104, mispredict=0.
- JALR, rs1=0x2003, imm=0, pred_target=0x2002, pred_taken=1 -> target=0x2002, mispredict=0.
- pc=0xFFFFFFFC, imm=8, BEQ with equal operands -> target=0x4 (wrap); funct3=010 -> taken=0, illegal=1.
- STAGES=2: stream 4 requests with out_ready low for 3 cycles -> in_ready drops after 2 accepted; all 4 delivered in order once out_ready rises; branch_count = 4.
- Flush with 2 results in flight and a new request presented -> out_valid = 0 the next cycle; counters unchanged; CNT_W=2 run of 5 handshakes -> branch_count saturates at 3.
